// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller driving an external 1-bit full-adder cell, LSB first.
// Latency: start accepted at edge k -> done pulse in the cycle after edge k+WIDTH -> idle after k+WIDTH+1.
// Backpressure: none; start is a request honoured only while idle (busy==0), otherwise ignored.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_s,
    input  logic             fa_c,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    // Bit counter only has to reach WIDTH-1.
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] sum_d;
    logic             run;
    logic             last_bit;

    assign run      = (state_q == S_RUN);
    assign last_bit = (cnt_q == CNT_LAST);
    assign cnt_d    = cnt_q + 1'b1;
    // Sum bits enter at the MSB so that after WIDTH shifts bit 0 is the first sum bit.
    assign sum_d    = {fa_s, sum_q[WIDTH-1:1]};

    // Full-adder operands are only presented while running; quiet otherwise.
    assign fa_a   = run & a_q[0];
    assign fa_b   = run & b_q[0];
    assign fa_cin = run & carry_q;

    assign sum  = sum_q;
    assign cout = cout_q;
    assign busy = busy_q;
    assign done = done_q;

    // Control FSM plus serial datapath; busy/done are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        // sum/cout are left alone: they keep the previous result until overwritten.
                        a_q     <= a_in;
                        b_q     <= b_in;
                        carry_q <= cin_in;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= fa_c;
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    if (last_bit) begin
                        // Wrap to zero instead of counting past WIDTH-1.
                        cnt_q   <= '0;
                        cout_q  <= fa_c;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_DONE: begin
                    // Result is on the outputs this cycle; return regardless of start.
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
